// File: rtl/fac_bus_master.sv
// fac_bus_master: bus initiator that batches operands into the factorial slave and returns the 64-bit results
// Build option: define FBM_POLL_MODE_EN to poll status register 0x9 instead of waiting for irq.
module fac_bus_master #(
    parameter int DEPTH    = 8,
    parameter int TIMEOUT  = 4096,
    parameter int POLL_GAP = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_n,
    input  logic        cmd_last,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_data,
    output logic        M_sel,
    output logic        M_wr,
    output logic [7:0]  M_address,
    output logic [31:0] M_dout,
    input  logic [31:0] M_din,
    input  logic        irq,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, COLLECT, WR_IEN, WR_N, WR_START, WAIT_DONE,
        RD_HI, RD_LO, EMIT, WR_CLEAR, DONE
    } state_t;

    state_t        state, state_nx;
    logic [31:0]   op_buf [DEPTH];
    logic [CW-1:0] cnt;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic          last_seen;
    logic [TW-1:0] tmo;
    logic          hi_cap, lo_cap;
    logic [31:0]   hi_q, lo_q;
    logic [41:0]   bus;
    logic          accept, full, complete, timeout, poll_rd;

    assign accept  = cmd_valid && cmd_ready;
    assign full    = cnt == CW'(DEPTH);
    assign timeout = (state == WAIT_DONE) && !complete && (tmo == TW'(TIMEOUT - 1));

`ifdef FBM_POLL_MODE_EN
    localparam int GW = $clog2(POLL_GAP + 2);
    localparam logic [31:0] IEN_VAL = 32'd0;

    logic [GW-1:0] gap;
    logic          poll_q;
    logic          unused_irq;

    assign unused_irq = irq;
    assign poll_rd    = (state == WAIT_DONE) && (gap == GW'(POLL_GAP));
    assign complete   = poll_q && M_din[0];

    // status poll scheduler: one read of 0x9 every POLL_GAP+1 cycles while waiting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap    <= '0;
            poll_q <= 1'b0;
        end else begin
            gap    <= (state == WAIT_DONE && !poll_rd) ? gap + GW'(1) : '0;
            poll_q <= poll_rd;
        end
    end
`else
    localparam logic [31:0] IEN_VAL = 32'd1;
    localparam int unused_poll_gap = POLL_GAP;

    assign poll_rd  = 1'b0;
    assign complete = irq;
`endif

    // operand storage; cnt gates every read so no reset is needed
    always_ff @(posedge clk) begin
        if (accept)
            op_buf[cnt[AW-1:0]] <= cmd_n;
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = accept ? COLLECT : IDLE;
            COLLECT:   state_nx = (last_seen || full) ? WR_IEN : COLLECT;
            WR_IEN:    state_nx = WR_N;
            WR_N:      state_nx = (wr_cnt == cnt - CW'(1)) ? WR_START : WR_N;
            WR_START:  state_nx = WAIT_DONE;
            WAIT_DONE: state_nx = complete ? RD_HI : timeout ? WR_CLEAR : WAIT_DONE;
            RD_HI:     state_nx = RD_LO;
            RD_LO:     state_nx = EMIT;
            EMIT:      state_nx = !(res_valid && res_ready) ? EMIT :
                                  (rd_cnt == cnt - CW'(1)) ? WR_CLEAR : RD_HI;
            WR_CLEAR:  state_nx = DONE;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // batch bookkeeping: operand, write and result counters plus the sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            last_seen <= 1'b0;
            err       <= 1'b0;
        end else if (state == DONE) begin
            cnt       <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            last_seen <= 1'b0;
        end else begin
            cnt       <= accept ? cnt + CW'(1) : cnt;
            last_seen <= accept ? cmd_last : last_seen;
            wr_cnt    <= (state == WR_N) ? wr_cnt + CW'(1) : wr_cnt;
            rd_cnt    <= (state == EMIT && res_valid && res_ready) ? rd_cnt + CW'(1) : rd_cnt;
            err       <= accept ? 1'b0 : timeout ? 1'b1 : err;
        end
    end

    // read data arrives the cycle after its address cycle; the wait counter runs only in WAIT_DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_cap <= 1'b0;
            lo_cap <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            tmo    <= '0;
        end else begin
            hi_cap <= state == RD_HI;
            lo_cap <= state == RD_LO;
            hi_q   <= hi_cap ? M_din : hi_q;
            lo_q   <= lo_cap ? M_din : lo_q;
            tmo    <= (state == WAIT_DONE) ? tmo + TW'(1) : '0;
        end
    end

    // outputs: bus cycle per state, handshakes and status; res_valid waits for the lo word capture
    always_comb begin
        bus = '0;
        case (state)
            WR_IEN:    bus = {2'b11, 8'h01, IEN_VAL};
            WR_N:      bus = {2'b11, 8'h03, op_buf[wr_cnt[AW-1:0]]};
            WR_START:  bus = {2'b11, 8'h02, 32'd1};
            WAIT_DONE: bus = poll_rd ? {2'b10, 8'h09, 32'd0} : '0;
            RD_HI,
            RD_LO:     bus = {2'b10, 8'h04, 32'd0};
            WR_CLEAR:  bus = {2'b11, 8'h00, 32'd1};
            default:   bus = '0;
        endcase
        cmd_ready = (state == IDLE) || (state == COLLECT && !last_seen && !full);
        res_valid = (state == EMIT) && !lo_cap;
        busy      = state != IDLE;
        done      = state == DONE;
    end

    assign {M_sel, M_wr, M_address, M_dout} = bus;
    assign res_data = {hi_q, lo_q};
endmodule

// File: tb/tb_fac_bus_master.sv
// tb_fac_bus_master: randomized bench with a behavioural factorial slave and expected bus trace model
module tb_fac_bus_master;
    localparam int DEPTH    = 8;
    localparam int TIMEOUT  = 64;
    localparam int POLL_GAP = 4;
`ifdef FBM_POLL_MODE_EN
    localparam logic [31:0] IEN_EXP = 32'd0;
`else
    localparam logic [31:0] IEN_EXP = 32'd1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_last;
    logic [31:0] cmd_n;
    logic        res_valid, res_ready;
    logic [63:0] res_data;
    logic        M_sel, M_wr;
    logic [7:0]  M_address;
    logic [31:0] M_dout, M_din;
    logic        irq, busy, done, err;

    always #5 clk = ~clk;

    fac_bus_master #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .POLL_GAP(POLL_GAP)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_n(cmd_n), .cmd_last(cmd_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .M_sel(M_sel), .M_wr(M_wr), .M_address(M_address), .M_dout(M_dout), .M_din(M_din),
        .irq(irq), .busy(busy), .done(done), .err(err)
    );

    int errors = 0;
    int checks = 0;

    function automatic logic [63:0] fact(input logic [31:0] n);
        logic [63:0] r = 64'd1;
        for (int i = 2; i <= int'(n); i++) r = r * 64'(i);
        return r;
    endfunction

    // bus monitor: every bus cycle except status polls goes to the trace
    int          cyc = 0;
    int          idle_bad = 0;
    logic [40:0] trace[$];
    int          trace_cyc[$];
    int          poll_cyc[$];
    always @(negedge clk) begin
        cyc++;
        if (M_sel && !(!M_wr && M_address == 8'h09)) begin
            trace.push_back({M_wr, M_address, M_wr ? M_dout : 32'd0});
            trace_cyc.push_back(cyc);
        end else if (M_sel)
            poll_cyc.push_back(cyc);
        else if (M_wr || M_address != 8'd0 || M_dout != 32'd0)
            idle_bad++;
    end

    // behavioural factorial slave with registered read data
    logic [31:0] s_nq[$];
    logic [31:0] s_rq[$];
    logic [63:0] s_f;
    logic        s_done, s_ien;
    int          s_lat;
    bit          slave_dead = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            s_nq.delete(); s_rq.delete();
            s_done <= 1'b0; s_ien <= 1'b0; s_lat <= 0; irq <= 1'b0; M_din <= 32'd0;
        end else begin
            if (M_sel && M_wr) begin
                if (M_address == 8'h00) begin
                    s_done <= 1'b0; s_nq.delete(); s_rq.delete();
                end else if (M_address == 8'h01)
                    s_ien <= M_dout[0];
                else if (M_address == 8'h02 && M_dout[0] && !slave_dead) begin
                    foreach (s_nq[i]) begin
                        s_f = fact(s_nq[i]);
                        s_rq.push_back(s_f[63:32]);
                        s_rq.push_back(s_f[31:0]);
                    end
                    s_nq.delete();
                    s_lat <= $urandom_range(12, 3);
                end else if (M_address == 8'h03)
                    s_nq.push_back(M_dout);
            end
            if (M_sel && !M_wr) begin
                if (M_address == 8'h04 && s_rq.size() > 0) M_din <= s_rq.pop_front();
                else if (M_address == 8'h09) M_din <= {31'd0, s_done};
                else M_din <= 32'd0;
            end
            if (s_lat > 0) begin
                s_lat <= s_lat - 1;
                if (s_lat == 1) s_done <= 1'b1;
            end
            irq <= s_done && s_ien;
        end
    end

    logic [63:0] got[$];
    bit          done_seen, busy_low, bound_hit;
    time         acc_t, done_t;

    task automatic send_op(input logic [31:0] n, input bit last);
        int w = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_n = n; cmd_last = last;
        while (!cmd_ready && w < 500) begin @(negedge clk); w++; end
        if (w >= 500) bound_hit = 1;
        @(posedge clk); #1;
        acc_t = $time;
        cmd_valid = 1'b0; cmd_last = 1'b0;
    endtask

    task automatic collect;
        int w = 0;
        got.delete(); done_seen = 0; busy_low = 0;
        while (!done_seen && w < 3000) begin
            @(negedge clk); w++;
            if (done) begin done_seen = 1; done_t = $time; end
            if (!busy && !done_seen) busy_low = 1;
            res_ready = ($urandom_range(3, 0) != 0);
            if (res_valid && res_ready) got.push_back(res_data);
        end
        if (!done_seen) bound_hit = 1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if ({M_sel, M_wr, M_address, M_dout} !== 42'd0) begin errors++; $display("FAIL reset_bus got %h want 0", {M_sel, M_wr, M_address, M_dout}); end
        checks++; if (res_data !== 64'd0) begin errors++; $display("FAIL reset_res_data got %h want 0", res_data); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got ready=%b busy=%b want 1 0", cmd_ready, busy); end
    endtask

    task automatic test_batch(input string name, input logic [31:0] ops[$]);
        logic [40:0] exp_tr[$];
        int sc = 0;
        trace.delete(); trace_cyc.delete(); poll_cyc.delete(); bound_hit = 0;
        foreach (ops[i]) send_op(ops[i], i == ops.size() - 1);
        collect();
        checks++; if (got.size() != ops.size()) begin errors++; $display("FAIL %s res_count got %0d want %0d", name, got.size(), ops.size()); end
        foreach (ops[i]) if (i < got.size()) begin
            checks++; if (got[i] !== fact(ops[i])) begin errors++; $display("FAIL %s res[%0d] got %h want %h", name, i, got[i], fact(ops[i])); end
        end
        exp_tr.push_back({1'b1, 8'h01, IEN_EXP});
        foreach (ops[i]) exp_tr.push_back({1'b1, 8'h03, ops[i]});
        exp_tr.push_back({1'b1, 8'h02, 32'd1});
        repeat (2 * ops.size()) exp_tr.push_back({1'b0, 8'h04, 32'd0});
        exp_tr.push_back({1'b1, 8'h00, 32'd1});
        checks++; if (trace.size() != exp_tr.size()) begin errors++; $display("FAIL %s trace_len got %0d want %0d", name, trace.size(), exp_tr.size()); end
        foreach (exp_tr[i]) if (i < trace.size()) begin
            checks++; if (trace[i] !== exp_tr[i]) begin errors++; $display("FAIL %s trace[%0d] got %h want %h", name, i, trace[i], exp_tr[i]); end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL %s err got %b want 0", name, err); end
        checks++; if (busy_low || bound_hit) begin errors++; $display("FAIL %s busy_or_bound got busy_low=%b bound=%b want 0 0", name, busy_low, bound_hit); end
`ifdef FBM_POLL_MODE_EN
        checks++; if (poll_cyc.size() == 0 || poll_cyc[0] - trace_cyc[ops.size() + 1] != POLL_GAP + 1) begin
            errors++; $display("FAIL %s first_poll got count=%0d want offset %0d", name, poll_cyc.size(), POLL_GAP + 1);
        end
        for (int i = 1; i < poll_cyc.size(); i++) if (poll_cyc[i] - poll_cyc[i - 1] != POLL_GAP + 1) sc++;
        checks++; if (sc != 0) begin errors++; $display("FAIL %s poll_spacing got %0d bad gaps want 0", name, sc); end
`else
        checks++; if (poll_cyc.size() != sc) begin errors++; $display("FAIL %s status_polls got %0d want 0", name, poll_cyc.size()); end
`endif
    endtask

    task automatic test_truncate;
        bound_hit = 0;
        for (int i = 0; i < DEPTH; i++) send_op(32'(i + 1), 1'b0);
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL trunc_ready_drop got %b want 0", cmd_ready); end
        fork
            send_op(32'd9, 1'b0);
            collect();
        join
        checks++; if (got.size() != DEPTH) begin errors++; $display("FAIL trunc_count got %0d want %0d", got.size(), DEPTH); end
        foreach (got[i]) begin
            checks++; if (got[i] !== fact(32'(i + 1))) begin errors++; $display("FAIL trunc_res[%0d] got %h want %h", i, got[i], fact(32'(i + 1))); end
        end
        checks++; if (acc_t <= done_t || bound_hit) begin errors++; $display("FAIL trunc_ninth_accept got t=%0t want after %0t", acc_t, done_t); end
        send_op(32'd10, 1'b1);
        collect();
        checks++; if (got.size() != 2 || got[0] !== fact(32'd9) || got[1] !== fact(32'd10)) begin
            errors++; $display("FAIL trunc_next_batch got n=%0d first=%h want 2 %h", got.size(), got.size() ? got[0] : 64'd0, fact(32'd9));
        end
    endtask

    task automatic test_stall;
        logic [63:0] d0;
        int tsz, bad = 0, w = 0;
        send_op(32'd6, 1'b0);
        send_op(32'd7, 1'b1);
        res_ready = 1'b0;
        while (!res_valid && w < 500) begin @(negedge clk); w++; end
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_wait got %b want 1", res_valid); end
        d0 = res_data; tsz = trace.size();
        repeat (20) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== d0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d unstable cycles want 0", bad); end
        checks++; if (trace.size() != tsz) begin errors++; $display("FAIL stall_bus_quiet got %0d cycles want %0d", trace.size(), tsz); end
        checks++; if (d0 !== fact(32'd6)) begin errors++; $display("FAIL stall_data got %h want %h", d0, fact(32'd6)); end
        collect();
        checks++; if (got.size() != 2 || got[0] !== fact(32'd6) || got[1] !== fact(32'd7)) begin
            errors++; $display("FAIL stall_results got n=%0d want 2", got.size());
        end
    endtask

    task automatic test_timeout;
        trace.delete(); trace_cyc.delete(); slave_dead = 1;
        send_op(32'd7, 1'b1);
        collect();
        checks++; if (got.size() != 0) begin errors++; $display("FAIL tmo_no_result got %0d want 0", got.size()); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b want 1", err); end
        checks++; if (trace.size() != 4) begin errors++; $display("FAIL tmo_trace_len got %0d want 4", trace.size()); end
        else begin
            checks++; if (trace_cyc[3] - trace_cyc[2] != TIMEOUT + 1) begin errors++; $display("FAIL tmo_wait_len got %0d want %0d", trace_cyc[3] - trace_cyc[2], TIMEOUT + 1); end
            checks++; if (trace[3] !== {1'b1, 8'h00, 32'd1}) begin errors++; $display("FAIL tmo_clear got %h want %h", trace[3], {1'b1, 8'h00, 32'd1}); end
        end
        slave_dead = 0;
        send_op(32'd3, 1'b1);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_clear got %b want 0", err); end
        collect();
        checks++; if (got.size() != 1 || got[0] !== 64'd6) begin errors++; $display("FAIL tmo_recover got n=%0d want 1 result 6", got.size()); end
    endtask

    task automatic test_reset_mid;
        send_op(32'd10, 1'b1);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || M_sel !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid got busy=%b ready=%b sel=%b valid=%b want 0 1 0 0", busy, cmd_ready, M_sel, res_valid);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q[$];
        cmd_valid = 1'b0; cmd_n = 32'd0; cmd_last = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        q = {32'd5};
        test_batch("single", q);
        q = {32'd3, 32'd4, 32'd20};
        test_batch("batch", q);
        for (int r = 0; r < 4; r++) begin
            q.delete();
            repeat ($urandom_range(DEPTH, 1)) q.push_back($urandom_range(20, 0));
            test_batch("random", q);
        end
        q.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back(32'(20 - i));
        test_batch("full_last", q);
        test_truncate();
        test_stall();
        test_timeout();
        test_reset_mid();
        q = {32'd0, 32'd1};
        test_batch("after_reset", q);
        checks++; if (idle_bad != 0) begin errors++; $display("FAIL idle_bus got %0d dirty cycles want 0", idle_bad); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
